// File: rtl/snow_pkg.sv
// Shared types and constants for the snowflake renderer.
package snow_pkg;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] speed;
  } flake_t;

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

  localparam logic [15:0] LFSR_TAPS   = 16'hB400;
  localparam logic [11:0] COLOR_FLAKE = 12'hFFF;
  localparam logic [11:0] COLOR_SKY   = 12'h003;
  localparam logic [11:0] COLOR_BLANK = 12'h000;

  // Flakes start on a diagonal, spread evenly across the screen.
  function automatic flake_t flake_init(input int unsigned i, input int unsigned n,
                                        input int unsigned h, input int unsigned v);
    flake_t f;
    f.x     = 10'(i * (h / n));
    f.y     = 10'(i * (v / n));
    f.speed = 2'(1 + (i % 3));
    return f;
  endfunction

endpackage

// File: rtl/snow_flakes_if.sv
// Video timing in / VGA pixel out bundle for the snowflake renderer.
interface snow_flakes_if;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic [3:0] vga_r;
  logic [3:0] vga_g;
  logic [3:0] vga_b;
  logic       vga_hsync;
  logic       vga_vsync;
  logic       vga_de;

  modport master (
    output sx, sy, hsync, vsync, de,
    input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de
  );

  modport slave (
    input  sx, sy, hsync, vsync, de,
    output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_de
  );
endinterface

// File: rtl/lfsr_galois16.sv
// 16-bit Galois LFSR that advances only when step is high.
module lfsr_galois16
  import snow_pkg::*;
(
  input  logic        clk_pix,
  input  logic        rst_pix,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step) begin
      lfsr_d = lfsr_q >> 1;
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) lfsr_q <= seed;
    else         lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/snow_flakes.sv
// Falling-snow pixel stage: per-frame flake update in blanking, registered
// colour output with syncs delayed to match.
module snow_flakes
  import snow_pkg::*;
#(
  parameter int unsigned N_FLAKES   = 8,
  parameter int unsigned FLAKE_SIZE = 4,
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic          clk_pix,
  input logic          rst_pix,
  snow_flakes_if.slave vid
);

  localparam int unsigned IW = $clog2(N_FLAKES);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  flake_t        flakes_q [N_FLAKES];
  flake_t        flakes_d [N_FLAKES];
  logic [15:0]   lfsr_val;
  logic          trigger, wr_en, respawn, lfsr_step, hit;
  logic [10:0]   y_sum;
  logic [9:0]    lx;
  flake_t        cur, nxt;
  logic [11:0]   color_d, color_q;
  logic          hsync_q, vsync_q, de_q;

  assign trigger = (vid.sx == '0) && (vid.sy == 10'(V_RES));

  lfsr_galois16 u_lfsr (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .step    (lfsr_step),
    .seed    (LFSR_SEED),
    .value   (lfsr_val)
  );

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N_FLAKES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en     = (state_q == UPDATE);
    cur       = flakes_q[idx_q];
    y_sum     = {1'b0, cur.y} + 11'(cur.speed);
    respawn   = (y_sum >= 11'(V_RES));
    lfsr_step = wr_en && respawn;
    lx        = lfsr_val[9:0];
    nxt       = cur;
    if (respawn) begin
      nxt.y     = '0;
      nxt.x     = (lx >= 10'(H_RES - FLAKE_SIZE)) ? (lx - 10'd512) : lx;
      nxt.speed = (lfsr_val[11:10] == 2'd0) ? 2'd1 : lfsr_val[11:10];
    end else begin
      nxt.y = y_sum[9:0];
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_FLAKES; i++) flakes_d[i] = flakes_q[i];
    if (wr_en) flakes_d[idx_q] = nxt;
  end

  always_ff @(posedge clk_pix) begin
    for (int unsigned i = 0; i < N_FLAKES; i++) begin
      if (rst_pix) flakes_q[i] <= flake_init(i, N_FLAKES, H_RES, V_RES);
      else         flakes_q[i] <= flakes_d[i];
    end
  end

  // 11-bit compares keep x+FLAKE_SIZE / y+FLAKE_SIZE from wrapping at the edges.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < N_FLAKES; i++) begin
      if (({1'b0, vid.sx} >= {1'b0, flakes_q[i].x}) &&
          ({1'b0, vid.sx} <  ({1'b0, flakes_q[i].x} + 11'(FLAKE_SIZE))) &&
          ({1'b0, vid.sy} >= {1'b0, flakes_q[i].y}) &&
          ({1'b0, vid.sy} <  ({1'b0, flakes_q[i].y} + 11'(FLAKE_SIZE))))
        hit = 1'b1;
    end
    if (!vid.de)  color_d = COLOR_BLANK;
    else if (hit) color_d = COLOR_FLAKE;
    else          color_d = COLOR_SKY;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      color_q <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
    end else begin
      color_q <= color_d;
      hsync_q <= vid.hsync;
      vsync_q <= vid.vsync;
      de_q    <= vid.de;
    end
  end

  assign vid.vga_r     = color_q[11:8];
  assign vid.vga_g     = color_q[7:4];
  assign vid.vga_b     = color_q[3:0];
  assign vid.vga_hsync = hsync_q;
  assign vid.vga_vsync = vsync_q;
  assign vid.vga_de    = de_q;

endmodule

// File: tb/tb_snow_flakes.sv
// Self-checking bench for snow_flakes with a frame-level flake/LFSR model.
module tb_snow_flakes;

  localparam int NF = 8;
  localparam int FS = 4;
  localparam int HR = 640;
  localparam int VR = 480;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  snow_flakes_if vif ();

  int checks   = 0;
  int failures = 0;
  int updates  = 0;
  int mx [NF];
  int my [NF];
  int ms [NF];
  logic [15:0] mlfsr;

  snow_flakes #(
    .N_FLAKES   (NF),
    .FLAKE_SIZE (FS),
    .H_RES      (HR),
    .V_RES      (VR),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk_pix (clk),
    .rst_pix (rst),
    .vid     (vif)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) begin
      mx[i] = i * (HR / NF);
      my[i] = i * (VR / NF);
      ms[i] = 1 + (i % 3);
    end
    mlfsr   = SEED;
    updates = 0;
  endtask

  task automatic model_update();
    int lxv, sp;
    for (int i = 0; i < NF; i++) begin
      if (my[i] + ms[i] >= VR) begin
        lxv   = int'(mlfsr[9:0]);
        mx[i] = (lxv >= HR - FS) ? lxv - 512 : lxv;
        sp    = int'(mlfsr[11:10]);
        ms[i] = (sp == 0) ? 1 : sp;
        my[i] = 0;
        mlfsr = lfsr_next(mlfsr);
      end else begin
        my[i] = my[i] + ms[i];
      end
    end
    updates++;
  endtask

  function automatic logic [11:0] model_rgb(input int px, input int py, input logic de);
    if (!de) return 12'h000;
    for (int i = 0; i < NF; i++)
      if (px >= mx[i] && px < mx[i] + FS && py >= my[i] && py < my[i] + FS) return 12'hFFF;
    return 12'h003;
  endfunction

  function automatic logic [11:0] rgb();
    return {vif.vga_r, vif.vga_g, vif.vga_b};
  endfunction

  task automatic drive(input int px, input int py, input logic hs, input logic vs, input logic de);
    vif.sx    = 10'(px);
    vif.sy    = 10'(py);
    vif.hsync = hs;
    vif.vsync = vs;
    vif.de    = de;
    @(posedge clk);
    #1;
  endtask

  // Trigger cycle followed by enough blanking cycles for the whole update.
  task automatic blank_frame_update();
    drive(0, VR, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < NF + 1; k++) drive(k + 1, VR + 1, 1'b1, 1'b0, 1'b0);
    model_update();
  endtask

  task automatic test_flake_positions(input string tag);
    int dx [5] = '{0, 3, 4, 0, -1};
    int dy [5] = '{0, 3, 0, 4, 0};
    int px, py;
    logic [11:0] exp;
    for (int i = 0; i < NF; i++) begin
      for (int p = 0; p < 5; p++) begin
        px = mx[i] + dx[p];
        py = my[i] + dy[p];
        if (px >= 0 && px < HR && py < VR) begin
          drive(px, py, 1'b1, 1'b1, 1'b1);
          exp = model_rgb(px, py, 1'b1);
          checks++;
          if (rgb() !== exp) begin
            failures++;
            $display("FAIL %s flake%0d (%0d,%0d) upd=%0d got=%h exp=%h", tag, i, px, py, updates, rgb(), exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(5, 5, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({vif.vga_hsync, vif.vga_vsync, vif.vga_de, rgb()} !== {3'b110, 12'h000}) begin
        failures++;
        $display("FAIL reset_out hs/vs/de/rgb got=%b%b%b/%h exp=110/000",
                 vif.vga_hsync, vif.vga_vsync, vif.vga_de, rgb());
      end
    end
    rst = 1'b0;
    model_reset();
    drive(0, 0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (rgb() !== 12'hFFF) begin
      failures++;
      $display("FAIL reset_first_pixel got=%h exp=fff", rgb());
    end
  endtask

  task automatic test_sync();
    logic hs, de;
    int lows = 0;
    for (int px = 0; px < 800; px++) begin
      hs = !(px >= 656 && px <= 751);
      de = (px < HR);
      drive(px, 10, hs, 1'b1, de);
      if (!vif.vga_hsync) lows++;
      checks++;
      if (vif.vga_hsync !== hs || vif.vga_de !== de || rgb() !== model_rgb(px, 10, de)) begin
        failures++;
        $display("FAIL sync sx=%0d hs/de/rgb got=%b/%b/%h exp=%b/%b/%h", px,
                 vif.vga_hsync, vif.vga_de, rgb(), hs, de, model_rgb(px, 10, de));
      end
    end
    checks++;
    if (lows != 96) begin
      failures++;
      $display("FAIL hsync_width got=%0d exp=96", lows);
    end
    for (int k = 0; k < 4; k++) begin
      drive(700, 490 + k, 1'b1, k[0], 1'b0);
      checks++;
      if (vif.vga_vsync !== k[0]) begin
        failures++;
        $display("FAIL vsync_pass got=%b exp=%b", vif.vga_vsync, k[0]);
      end
    end
  endtask

  task automatic test_background();
    drive(300, 300, 1'b1, 1'b1, 1'b1);
    checks++;
    if (rgb() !== 12'h003) begin
      failures++;
      $display("FAIL bg_sky got=%h exp=003", rgb());
    end
    drive(0, 0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (rgb() !== 12'h000) begin
      failures++;
      $display("FAIL bg_blank got=%h exp=000", rgb());
    end
  endtask

  task automatic test_fall();
    logic [11:0] got [4];
    logic [11:0] exp [4] = '{12'h003, 12'hFFF, 12'hFFF, 12'h003};
    blank_frame_update();
    drive(0, 0, 1'b1, 1'b1, 1'b1);   got[0] = rgb();
    drive(0, 1, 1'b1, 1'b1, 1'b1);   got[1] = rgb();
    drive(80, 62, 1'b1, 1'b1, 1'b1); got[2] = rgb();
    drive(80, 61, 1'b1, 1'b1, 1'b1); got[3] = rgb();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got[k] !== exp[k]) begin
        failures++;
        $display("FAIL fall_probe%0d got=%h exp=%h", k, got[k], exp[k]);
      end
    end
    test_flake_positions("fall");
  endtask

  task automatic test_respawn(input string tag);
    while (updates < 30) begin
      blank_frame_update();
      test_flake_positions(tag);
    end
    drive(mx[7], 0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (rgb() !== 12'hFFF) begin
      failures++;
      $display("FAIL %s_flake7 x=%0d got=%h exp=fff", tag, mx[7], rgb());
    end
  endtask

  task automatic test_random();
    int px, py;
    logic de;
    for (int f = 0; f < 60; f++) begin
      blank_frame_update();
      for (int k = 0; k < 12; k++) begin
        px = int'($urandom_range(HR - 1));
        py = int'($urandom_range(VR - 1));
        de = 1'($urandom_range(1));
        drive(px, py, 1'b1, 1'b1, de);
        checks++;
        if (rgb() !== model_rgb(px, py, de)) begin
          failures++;
          $display("FAIL random (%0d,%0d) de=%b upd=%0d got=%h exp=%h",
                   px, py, de, updates, rgb(), model_rgb(px, py, de));
        end
      end
      test_flake_positions("random");
    end
  endtask

  task automatic test_reset_mid_update();
    drive(0, VR, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) drive(k + 1, VR + 1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    drive(4, VR + 1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (vif.vga_hsync !== 1'b1 || rgb() !== 12'h000) begin
      failures++;
      $display("FAIL midrst_out hs/rgb got=%b/%h exp=1/000", vif.vga_hsync, rgb());
    end
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < NF; k++) drive(k + 5, VR + 1, 1'b1, 1'b0, 1'b0);
    test_flake_positions("midrst_init");
    test_respawn("midrst");
  endtask

  task automatic test_reset_on_trigger();
    rst = 1'b1;
    drive(0, VR, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < NF + 2; k++) drive(k + 1, VR + 1, 1'b1, 1'b0, 1'b0);
    test_flake_positions("rst_trig");
  endtask

  initial begin
    vif.sx = '0; vif.sy = '0; vif.hsync = 1'b1; vif.vsync = 1'b1; vif.de = 1'b0;
    test_reset();
    test_sync();
    test_background();
    test_fall();
    test_respawn("respawn");
    test_random();
    test_reset_mid_update();
    test_reset_on_trigger();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snow_flakes.md
# snow_flakes

Pixel-stage renderer that sits directly downstream of the 640x480 display timing generator. It consumes the screen position, sync and data-enable signals, and animates a fixed set of falling snowflakes. Flake positions are updated once per frame during vertical blanking. Each pixel is coloured as flake or background, and the output is registered with syncs delayed to match, ready for the VGA/DVI output pins.

## Interface
- `N_FLAKES`, 8: number of flakes; power of two, 2..32.
- `FLAKE_SIZE`, 4: flake edge length in pixels (square).
- `H_RES`, 640: active width.
- `V_RES`, 480: active height.
- `LFSR_SEED`, 16'hACE1: reset value of the respawn LFSR; must be nonzero.

- `clk_pix` input 1: pixel clock.
- `rst_pix` input 1: reset; synchronous, active-high.
- `sx` input 10: horizontal position from the timing generator.
- `sy` input 10: vertical position from the timing generator.
- `hsync` input 1: horizontal sync, negative polarity.
- `vsync` input 1: vertical sync, negative polarity.
- `de` input 1: data enable.
- `vga_r` output 4: red.
- `vga_g` output 4: green.
- `vga_b` output 4: blue.
- `vga_hsync` output 1: `hsync` delayed 1 cycle.
- `vga_vsync` output 1: `vsync` delayed 1 cycle.
- `vga_de` output 1: `de` delayed 1 cycle.

## Operation
- **Per-flake state:** x (10b), y (10b), speed (2b, range 1..3).
- **Reset state of flake i:**
  - x = i*(H_RES/N_FLAKES)
  - y = i*(V_RES/N_FLAKES)
  - speed = 1 + (i mod 3)
- **LFSR:** 16-bit Galois, taps 16'hB400. It advances exactly once per respawn, never otherwise.
- **Update FSM states:**
  - IDLE → UPDATE when sx==0 && sy==V_RES (first blanking line). The flake index resets to 0.
  - UPDATE: processes one flake per cycle, index 0..N_FLAKES-1, then → IDLE. It occupies N_FLAKES cycles.
- **Flake update:**
  - If y+speed (11-bit sum) ≥ V_RES, respawn: y=0, x = L[9:0] ≥ H_RES-FLAKE_SIZE ? L[9:0]-512 : L[9:0], speed = L[11:10]==0 ? 1 : L[11:10]. L is the current LFSR value, and the LFSR steps in the same cycle.
  - Otherwise y = y+speed; x and speed are unchanged.
- **Pixel hit:** de && any flake with x ≤ sx < x+FLAKE_SIZE and y ≤ sy < y+FLAKE_SIZE. Use 11-bit compares so flakes near the right or bottom edge do not wrap.
- **Colour:**
  - hit → F/F/F
  - de && !hit → 0/0/3 (night blue)
  - !de → 0/0/0
- Flake state changes only during vertical blanking, so there is no tearing within a frame.

## Timing
- Latency is 1 clock: colour for (sx,sy) and the delayed syncs/de appear together on the next edge.
- **Reset values:** vga_r/g/b = 0, vga_hsync = 1, vga_vsync = 1, vga_de = 0, FSM = IDLE, LFSR = LFSR_SEED, flakes at their reset state.
- **rst_pix mid-UPDATE:** the FSM aborts to IDLE and all flakes return to their reset state; no partial update persists.
- **rst_pix on the trigger cycle:** reset wins and no update starts that frame.
- The trigger occurs once per frame. UPDATE completes in N_FLAKES ≤ 32 cycles, well inside blanking, so no overlapping triggers are possible.
- Only one flake is written per cycle, and there is one LFSR step per respawn, so simultaneous respawns cannot occur.

## Structure
- **Package `snow_pkg`:**
  - typedef `flake_t` (x, y, speed)
  - LFSR tap constant
  - background/flake colour constants
  - FSM state enum {IDLE, UPDATE}
- **Sub-module `lfsr_galois16`:** ports clk_pix, rst_pix, step, seed, value. It steps only when `step` is high.
- The hit compare across N_FLAKES is a combinational OR-reduce in the top module, feeding the output register.

## Test plan
- **Reset output values:** hold rst_pix for 3 cycles → vga_hsync = vga_vsync = 1, vga_de = 0, rgb = 0. The first pixel after release at (0,0) produces F/F/F one cycle later, because flake 0 starts at (0,0).
- **Sync passthrough:** hsync low for sx = 656..751 → vga_hsync low exactly one cycle later, for 96 cycles. vga_de mirrors de with 1-cycle delay.
- **Background colour:** pixel (300,300) in frame 0 (no flake there) → 0/0/3. Any pixel with de=0 → 0/0/0.
- **Per-frame fall:** after the first frame, the update at sy=480 moves flake 0 to y=1 and flake 1 (y=60, speed 2) to y=62. Pixel (0,0) in frame 1 → 0/0/3; pixel (0,1) → F/F/F.
- **Respawn:** flake 7 (y=420, speed 2) respawns on update 30 → y=0, with x and speed matching the software LFSR model from LFSR_SEED. The LFSR does not step before that update.
- **Reset mid-update:** assert rst_pix at cycle 3 of UPDATE → all flakes at their reset positions and the LFSR at LFSR_SEED. The next frame behaves identically to frame 0.
